// File: rtl/flit_tx_if.sv
// Descriptor, payload and arbiter-facing flit signals of one flit_tx port.
// master: the transmitter; slave: the driver/arbiter side.
interface flit_tx_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEST_W = 4
);
  logic              pkt_valid;
  logic              pkt_ready;
  logic [11:0]       pkt_len;
  logic [DEST_W-1:0] pkt_dest;
  logic              data_valid;
  logic              data_ready;
  logic [DATA_W-1:0] data_in;
  logic              req;
  logic              grant;
  logic [2:0]        flit_id;
  logic [11:0]       length;
  logic              flit_valid;
  logic [DATA_W-1:0] flit_data;
  logic              err;

  modport master (
    input  pkt_valid, pkt_len, pkt_dest, data_valid, data_in, grant,
    output pkt_ready, data_ready, req, flit_id, length, flit_valid, flit_data, err
  );

  modport slave (
    output pkt_valid, pkt_len, pkt_dest, data_valid, data_in, grant,
    input  pkt_ready, data_ready, req, flit_id, length, flit_valid, flit_data, err
  );
endinterface

// File: rtl/flit_tx.sv
// Per-port packet transmitter: payload FIFO plus header/body/tail FSM toward the arbiter.
// Optional grant-wait watchdog is enabled by defining FLIT_TX_WATCHDOG_EN.
module flit_tx #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEST_W     = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WD_CYCLES  = 1024
) (
  input logic       clk,
  input logic       rst,
  flit_tx_if.master bus
);
  typedef enum logic [2:0] {StIdle, StReq, StHead, StBody, StTail} state_e;

  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW    = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);
  localparam logic [2:0] IdIdle = 3'b000;
  localparam logic [2:0] IdHead = 3'b001;
  localparam logic [2:0] IdBody = 3'b010;
  localparam logic [2:0] IdTail = 3'b100;

  state_e            state_q, state_d;
  logic [11:0]       len_q, len_d, rem_q, rem_d, len_in;
  logic [DEST_W-1:0] dest_q, dest_d;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d, drop;
  logic              push, pop, flush, emit, wd_fire;

  logic              pkt_ready_q, pkt_ready_d, data_ready_q, req_q, req_d;
  logic              flit_valid_q, flit_valid_d, err_q, err_d;
  logic [2:0]        flit_id_q, flit_id_d;
  logic [11:0]       length_q, length_d;
  logic [DATA_W-1:0] flit_data_q, flit_data_d;

  assign push = bus.data_valid & data_ready_q;

  // On abort, discard only the queued words that belong to the aborted packet.
  always_comb begin
    drop = '0;
    if (flush) drop = (rem_q < 12'(cnt_q)) ? rem_q[CntW-1:0] : cnt_q;
    else if (pop) drop = CntW'(1);
    cnt_d    = cnt_q + CntW'(push) - drop;
    rd_ptr_d = rd_ptr_q + drop[PtrW-1:0];
  end

`ifdef FLIT_TX_WATCHDOG_EN
  localparam int unsigned WdW = ($clog2(WD_CYCLES + 1) > 12) ? $clog2(WD_CYCLES + 1) : 12;
  logic [WdW-1:0] wd_q, wd_d;

  always_comb begin
    wd_d = wd_q;
    if (state_q == StIdle || bus.grant) wd_d = '0;
    else if (state_q == StReq || rem_q != '0) wd_d = wd_q + WdW'(1);
    wd_fire = (wd_d == WdW'(WD_CYCLES));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wd_q <= '0;
    else      wd_q <= wd_fire ? '0 : wd_d;
  end
`else
  logic unused_wd;
  assign wd_fire   = 1'b0;
  assign unused_wd = (WD_CYCLES == 0);
`endif

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    dest_d       = dest_q;
    rem_d        = rem_q;
    pkt_ready_d  = 1'b0;
    req_d        = 1'b0;
    flit_id_d    = IdIdle;
    length_d     = '0;
    flit_valid_d = 1'b0;
    flit_data_d  = '0;
    err_d        = 1'b0;
    pop          = 1'b0;
    flush        = 1'b0;
    len_in       = (bus.pkt_len < 12'd2) ? 12'd2 : bus.pkt_len;
    emit         = bus.grant && (cnt_q != '0) && (rem_q != '0);
    // Outputs are registered, so each branch computes what the next cycle presents.
    unique case (state_q)
      StIdle: begin
        pkt_ready_d = 1'b1;
        if (bus.pkt_valid && pkt_ready_q) begin
          len_d       = len_in;
          dest_d      = bus.pkt_dest;
          rem_d       = len_in - 12'd1;
          state_d     = StReq;
          pkt_ready_d = 1'b0;
          req_d       = 1'b1;
          flit_id_d   = IdHead;
          length_d    = len_in;
        end
      end
      StReq: begin
        req_d     = 1'b1;
        flit_id_d = IdHead;
        length_d  = len_q;
        if (bus.grant) begin
          state_d      = StHead;
          flit_valid_d = 1'b1;
          flit_data_d  = DATA_W'({dest_q, len_q});
        end
      end
      StHead, StBody, StTail: begin
        if (state_q == StTail && rem_q == '0) begin
          state_d     = StIdle;
          pkt_ready_d = 1'b1;
        end else begin
          req_d     = 1'b1;
          length_d  = len_q;
          state_d   = (rem_q == 12'd1) ? StTail : StBody;
          flit_id_d = (rem_q == 12'd1) ? IdTail : IdBody;
          if (emit) begin
            pop          = 1'b1;
            rem_d        = rem_q - 12'd1;
            flit_valid_d = 1'b1;
            flit_data_d  = mem_q[rd_ptr_q];
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (wd_fire) begin
      state_d      = StIdle;
      pkt_ready_d  = 1'b1;
      req_d        = 1'b0;
      flit_id_d    = IdIdle;
      length_d     = '0;
      flit_valid_d = 1'b0;
      flit_data_d  = '0;
      err_d        = 1'b1;
      pop          = 1'b0;
      flush        = 1'b1;
      rem_d        = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      len_q        <= '0;
      dest_q       <= '0;
      rem_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      pkt_ready_q  <= 1'b0;
      data_ready_q <= 1'b0;
      req_q        <= 1'b0;
      flit_id_q    <= IdIdle;
      length_q     <= '0;
      flit_valid_q <= 1'b0;
      flit_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      dest_q       <= dest_d;
      rem_q        <= rem_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      pkt_ready_q  <= pkt_ready_d;
      data_ready_q <= (cnt_d != CntFull);
      req_q        <= req_d;
      flit_id_q    <= flit_id_d;
      length_q     <= length_d;
      flit_valid_q <= flit_valid_d;
      flit_data_q  <= flit_data_d;
      err_q        <= err_d;
    end
  end

  assign bus.pkt_ready  = pkt_ready_q;
  assign bus.data_ready = data_ready_q;
  assign bus.req        = req_q;
  assign bus.flit_id    = flit_id_q;
  assign bus.length     = length_q;
  assign bus.flit_valid = flit_valid_q;
  assign bus.flit_data  = flit_data_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_flit_tx.sv
// Directed bench for flit_tx: packet sequencing, grant loss, FIFO bubbles, watchdog, reset.
module tb_flit_tx;
  localparam int unsigned DataW = 32;
  localparam int unsigned DestW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  flit_tx_if #(.DATA_W(DataW), .DEST_W(DestW)) bus ();

  flit_tx #(
    .DATA_W    (DataW),
    .DEST_W    (DestW),
    .FIFO_DEPTH(4),
    .WD_CYCLES (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    int n = 0;
    while (bus.data_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    vectors++;
    if (bus.data_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL push_wait: data_ready=%b required 1", bus.data_ready);
    end
    bus.data_valid = 1'b1;
    bus.data_in    = w;
    step();
    bus.data_valid = 1'b0;
  endtask

  task automatic send_desc(input logic [11:0] len, input logic [3:0] dest);
    int n = 0;
    while (bus.pkt_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    vectors++;
    if (bus.pkt_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL desc_wait: pkt_ready=%b required 1", bus.pkt_ready);
    end
    bus.pkt_valid = 1'b1;
    bus.pkt_len   = len;
    bus.pkt_dest  = dest;
    step();
    bus.pkt_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    vectors++;
    if ({bus.pkt_ready, bus.data_ready, bus.req, bus.flit_id, bus.length, bus.flit_valid,
         bus.flit_data, bus.err} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: pr=%b dr=%b req=%b id=%b len=%0d fv=%b fd=%h err=%b required all 0",
               bus.pkt_ready, bus.data_ready, bus.req, bus.flit_id, bus.length, bus.flit_valid,
               bus.flit_data, bus.err);
    end
    rst = 1'b1;
    step();
    vectors++;
    if (bus.pkt_ready !== 1'b1 || bus.data_ready !== 1'b1 || bus.req !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: pr=%b dr=%b req=%b required 1 1 0",
               bus.pkt_ready, bus.data_ready, bus.req);
    end
  endtask

  task automatic test_basic();
    push_word(32'hAAAA_0001);
    push_word(32'hBBBB_0002);
    push_word(32'hCCCC_0003);
    send_desc(12'd4, 4'd3);
    vectors++;
    if (bus.req !== 1'b1 || bus.flit_id !== 3'b001 || bus.length !== 12'd4 ||
        bus.flit_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_req1: req=%b id=%b len=%0d fv=%b required 1 001 4 0",
               bus.req, bus.flit_id, bus.length, bus.flit_valid);
    end
    step();
    vectors++;
    if (bus.req !== 1'b1 || bus.flit_valid !== 1'b0 || bus.length !== 12'd4) begin
      miscompares++;
      $display("FAIL basic_req2: req=%b fv=%b len=%0d required 1 0 4",
               bus.req, bus.flit_valid, bus.length);
    end
    bus.grant = 1'b1;
    step();
    vectors++;
    if (bus.flit_valid !== 1'b1 || bus.flit_id !== 3'b001 || bus.flit_data !== 32'h0000_3004) begin
      miscompares++;
      $display("FAIL basic_head: fv=%b id=%b d=%h required 1 001 00003004",
               bus.flit_valid, bus.flit_id, bus.flit_data);
    end
    step();
    vectors++;
    if (bus.flit_valid !== 1'b1 || bus.flit_id !== 3'b010 || bus.flit_data !== 32'hAAAA_0001) begin
      miscompares++;
      $display("FAIL basic_body_a: fv=%b id=%b d=%h required 1 010 aaaa0001",
               bus.flit_valid, bus.flit_id, bus.flit_data);
    end
    step();
    vectors++;
    if (bus.flit_valid !== 1'b1 || bus.flit_id !== 3'b010 || bus.flit_data !== 32'hBBBB_0002) begin
      miscompares++;
      $display("FAIL basic_body_b: fv=%b id=%b d=%h required 1 010 bbbb0002",
               bus.flit_valid, bus.flit_id, bus.flit_data);
    end
    step();
    vectors++;
    if (bus.flit_valid !== 1'b1 || bus.flit_id !== 3'b100 || bus.flit_data !== 32'hCCCC_0003 ||
        bus.req !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_tail: fv=%b id=%b d=%h req=%b required 1 100 cccc0003 1",
               bus.flit_valid, bus.flit_id, bus.flit_data, bus.req);
    end
    step();
    vectors++;
    if (bus.req !== 1'b0 || bus.flit_valid !== 1'b0 || bus.flit_id !== 3'b000 ||
        bus.pkt_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_after: req=%b fv=%b id=%b pr=%b required 0 0 000 1",
               bus.req, bus.flit_valid, bus.flit_id, bus.pkt_ready);
    end
    bus.grant = 1'b0;
  endtask

  task automatic test_short();
    push_word(32'hDDDD_0004);
    send_desc(12'd2, 4'd5);
    bus.grant = 1'b1;
    step();
    vectors++;
    if (bus.flit_valid !== 1'b1 || bus.flit_id !== 3'b001 || bus.flit_data !== 32'h0000_5002) begin
      miscompares++;
      $display("FAIL short_head: fv=%b id=%b d=%h required 1 001 00005002",
               bus.flit_valid, bus.flit_id, bus.flit_data);
    end
    step();
    vectors++;
    if (bus.flit_valid !== 1'b1 || bus.flit_id !== 3'b100 || bus.flit_data !== 32'hDDDD_0004) begin
      miscompares++;
      $display("FAIL short_tail: fv=%b id=%b d=%h required 1 100 dddd0004",
               bus.flit_valid, bus.flit_id, bus.flit_data);
    end
    step();
    vectors++;
    if (bus.pkt_ready !== 1'b1 || bus.req !== 1'b0 || bus.flit_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL short_after: pr=%b req=%b fv=%b required 1 0 0",
               bus.pkt_ready, bus.req, bus.flit_valid);
    end
    bus.grant = 1'b0;
  endtask

  task automatic test_grant_loss();
    logic [31:0] exp_body [2];
    for (int i = 0; i < 4; i++) push_word(32'h1000_0000 + 32'(i));
    send_desc(12'd6, 4'd9);
    bus.grant = 1'b1;
    step();
    vectors++;
    if (bus.flit_valid !== 1'b1 || bus.flit_id !== 3'b001 || bus.flit_data !== 32'h0000_9006) begin
      miscompares++;
      $display("FAIL gl_head: fv=%b id=%b d=%h required 1 001 00009006",
               bus.flit_valid, bus.flit_id, bus.flit_data);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if (bus.flit_valid !== 1'b1 || bus.flit_id !== 3'b010 ||
          bus.flit_data !== 32'h1000_0000 + 32'(i)) begin
        miscompares++;
        $display("FAIL gl_body%0d: fv=%b id=%b d=%h required 1 010 %h",
                 i, bus.flit_valid, bus.flit_id, bus.flit_data, 32'h1000_0000 + 32'(i));
      end
    end
    bus.grant      = 1'b0;
    bus.data_valid = 1'b1;
    bus.data_in    = 32'h1000_0004;
    for (int i = 0; i < 3; i++) begin
      step();
      bus.data_valid = 1'b0;
      vectors++;
      if (bus.flit_valid !== 1'b0 || bus.req !== 1'b1) begin
        miscompares++;
        $display("FAIL gl_bubble%0d: fv=%b req=%b required 0 1", i, bus.flit_valid, bus.req);
      end
    end
    bus.grant   = 1'b1;
    exp_body[0] = 32'h1000_0002;
    exp_body[1] = 32'h1000_0003;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if (bus.flit_valid !== 1'b1 || bus.flit_id !== 3'b010 || bus.flit_data !== exp_body[i]) begin
        miscompares++;
        $display("FAIL gl_resume%0d: fv=%b id=%b d=%h required 1 010 %h",
                 i, bus.flit_valid, bus.flit_id, bus.flit_data, exp_body[i]);
      end
    end
    step();
    vectors++;
    if (bus.flit_valid !== 1'b1 || bus.flit_id !== 3'b100 || bus.flit_data !== 32'h1000_0004) begin
      miscompares++;
      $display("FAIL gl_tail: fv=%b id=%b d=%h required 1 100 10000004",
               bus.flit_valid, bus.flit_id, bus.flit_data);
    end
    step();
    vectors++;
    if (bus.req !== 1'b0 || bus.flit_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL gl_after: req=%b fv=%b required 0 0", bus.req, bus.flit_valid);
    end
    bus.grant = 1'b0;
  endtask

  task automatic test_fifo_empty();
    push_word(32'hE000_0000);
    send_desc(12'd4, 4'd2);
    bus.grant = 1'b1;
    step();
    vectors++;
    if (bus.flit_valid !== 1'b1 || bus.flit_id !== 3'b001 || bus.flit_data !== 32'h0000_2004) begin
      miscompares++;
      $display("FAIL fe_head: fv=%b id=%b d=%h required 1 001 00002004",
               bus.flit_valid, bus.flit_id, bus.flit_data);
    end
    step();
    vectors++;
    if (bus.flit_valid !== 1'b1 || bus.flit_id !== 3'b010 || bus.flit_data !== 32'hE000_0000) begin
      miscompares++;
      $display("FAIL fe_body0: fv=%b id=%b d=%h required 1 010 e0000000",
               bus.flit_valid, bus.flit_id, bus.flit_data);
    end
    step();
    vectors++;
    if (bus.flit_valid !== 1'b0 || bus.req !== 1'b1) begin
      miscompares++;
      $display("FAIL fe_bubble0: fv=%b req=%b required 0 1", bus.flit_valid, bus.req);
    end
    bus.data_valid = 1'b1;
    bus.data_in    = 32'hE000_0001;
    step();
    vectors++;
    if (bus.flit_valid !== 1'b0 || bus.req !== 1'b1 || bus.data_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL fe_bubble1: fv=%b req=%b dr=%b required 0 1 1",
               bus.flit_valid, bus.req, bus.data_ready);
    end
    bus.data_in = 32'hE000_0002;
    step();
    bus.data_valid = 1'b0;
    vectors++;
    if (bus.flit_valid !== 1'b1 || bus.flit_id !== 3'b010 || bus.flit_data !== 32'hE000_0001) begin
      miscompares++;
      $display("FAIL fe_body1: fv=%b id=%b d=%h required 1 010 e0000001",
               bus.flit_valid, bus.flit_id, bus.flit_data);
    end
    step();
    vectors++;
    if (bus.flit_valid !== 1'b1 || bus.flit_id !== 3'b100 || bus.flit_data !== 32'hE000_0002) begin
      miscompares++;
      $display("FAIL fe_tail: fv=%b id=%b d=%h required 1 100 e0000002",
               bus.flit_valid, bus.flit_id, bus.flit_data);
    end
    step();
    vectors++;
    if (bus.req !== 1'b0 || bus.pkt_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL fe_after: req=%b pr=%b required 0 1", bus.req, bus.pkt_ready);
    end
    bus.grant = 1'b0;
  endtask

  task automatic test_watchdog();
    push_word(32'hF00D_0000);
    send_desc(12'd3, 4'd1);
`ifdef FLIT_TX_WATCHDOG_EN
    for (int i = 1; i <= 16; i++) begin
      step();
      vectors++;
      if (i < 16) begin
        if (bus.err !== 1'b0 || bus.req !== 1'b1) begin
          miscompares++;
          $display("FAIL wd_wait%0d: err=%b req=%b required 0 1", i, bus.err, bus.req);
        end
      end else if (bus.err !== 1'b1 || bus.req !== 1'b0 || bus.pkt_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL wd_fire: err=%b req=%b pr=%b required 1 0 1",
                 bus.err, bus.req, bus.pkt_ready);
      end
    end
    step();
    vectors++;
    if (bus.err !== 1'b0 || bus.req !== 1'b0) begin
      miscompares++;
      $display("FAIL wd_after: err=%b req=%b required 0 0", bus.err, bus.req);
    end
`else
    for (int i = 0; i < 40; i++) begin
      step();
      vectors++;
      if (bus.req !== 1'b1 || bus.err !== 1'b0 || bus.flit_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL nowd_wait%0d: req=%b err=%b fv=%b required 1 0 0",
                 i, bus.req, bus.err, bus.flit_valid);
      end
    end
`endif
  endtask

  task automatic test_reset_mid();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    for (int i = 0; i < 3; i++) push_word(32'h6000_0000 + 32'(i));
    send_desc(12'd5, 4'd1);
    bus.grant = 1'b1;
    step();
    step();
    vectors++;
    if (bus.flit_valid !== 1'b1 || bus.flit_id !== 3'b010 || bus.flit_data !== 32'h6000_0000) begin
      miscompares++;
      $display("FAIL rm_body: fv=%b id=%b d=%h required 1 010 60000000",
               bus.flit_valid, bus.flit_id, bus.flit_data);
    end
    rst = 1'b0;
    #2;
    vectors++;
    if ({bus.pkt_ready, bus.data_ready, bus.req, bus.flit_id, bus.length, bus.flit_valid,
         bus.flit_data, bus.err} !== '0) begin
      miscompares++;
      $display("FAIL rm_async: pr=%b dr=%b req=%b id=%b len=%0d fv=%b fd=%h err=%b required all 0",
               bus.pkt_ready, bus.data_ready, bus.req, bus.flit_id, bus.length, bus.flit_valid,
               bus.flit_data, bus.err);
    end
    bus.grant = 1'b0;
    step();
    rst = 1'b1;
    push_word(32'h7777_0007);
    send_desc(12'd2, 4'd7);
    bus.grant = 1'b1;
    step();
    vectors++;
    if (bus.flit_valid !== 1'b1 || bus.flit_id !== 3'b001 || bus.flit_data !== 32'h0000_7002) begin
      miscompares++;
      $display("FAIL rm_new_head: fv=%b id=%b d=%h required 1 001 00007002",
               bus.flit_valid, bus.flit_id, bus.flit_data);
    end
    step();
    vectors++;
    if (bus.flit_valid !== 1'b1 || bus.flit_id !== 3'b100 || bus.flit_data !== 32'h7777_0007) begin
      miscompares++;
      $display("FAIL rm_new_tail: fv=%b id=%b d=%h required 1 100 77770007",
               bus.flit_valid, bus.flit_id, bus.flit_data);
    end
    step();
    vectors++;
    if (bus.req !== 1'b0 || bus.pkt_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rm_after: req=%b pr=%b required 0 1", bus.req, bus.pkt_ready);
    end
    bus.grant = 1'b0;
  endtask

  initial begin
    bus.pkt_valid  = 1'b0;
    bus.pkt_len    = '0;
    bus.pkt_dest   = '0;
    bus.data_valid = 1'b0;
    bus.data_in    = '0;
    bus.grant      = 1'b0;
    test_reset();
    test_basic();
    test_short();
    test_grant_loss();
    test_fifo_empty();
    test_watchdog();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
